// File: rtl/demux_14_seq.sv
`default_nettype none
// ============================================================================
// Module      : demux_14_seq
// Description : Registered 1-to-4 demultiplexer. Each valid input sample is
//               steered to one of four channel registers. The channel comes
//               from an explicit select (manual mode) or from a round-robin
//               pointer locked to a start-of-frame marker (auto mode). In
//               auto mode, complete 4-sample frames are reassembled and
//               framing errors are flagged.
// Ports       : clk         - system clock, rising edge
//               rst_n       - synchronous active-low reset
//               din         - input sample (W bits)
//               din_valid   - din is valid this cycle
//               sof         - start of frame, marks the channel-0 sample
//               auto_mode   - 1 = framed round-robin, 0 = manual select
//               sel         - manual-mode destination channel
//               ch_out      - channel registers, slice k = ch_out[k*W +: W]
//               ch_valid    - per-channel write pulse
//               frame_out   - last complete frame, slice k = channel-k sample
//               frame_valid - pulse when frame_out is updated
//               err         - framing error pulse
// Revision    : 1.0 - initial release
// ============================================================================
module demux_14_seq #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           sof,
    input  logic           auto_mode,
    input  logic [1:0]     sel,
    output logic [4*W-1:0] ch_out,
    output logic [3:0]     ch_valid,
    output logic [4*W-1:0] frame_out,
    output logic           frame_valid,
    output logic           err
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [4*W-1:0] ch_q, ch_d;
    logic [3:0]     chv_q, chv_d;
    logic [4*W-1:0] frame_q, frame_d;
    logic           fv_q, fv_d;
    logic           err_q, err_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        chv_d   = 4'b0000;
        frame_d = frame_q;
        fv_d    = 1'b0;
        err_d   = 1'b0;

        if (!auto_mode) begin
            // Holding the framer idle here means entering auto mode always
            // starts from a clean frame boundary.
            state_d = IDLE;
            ptr_d   = 2'd0;
            if (din_valid) begin
                ch_d[int'(sel)*W +: W] = din;
                chv_d                  = 4'b0001 << sel;
            end
        end else if (din_valid) begin
            case (state_q)
                IDLE: begin
                    if (sof) begin
                        ch_d[0 +: W] = din;
                        chv_d        = 4'b0001;
                        ptr_d        = 2'd1;
                        state_d      = COLLECT;
                    end else begin
                        // Sample outside any frame: drop it and flag it.
                        err_d = 1'b1;
                    end
                end
                COLLECT: begin
                    if (sof) begin
                        // Resync: abandon the partial frame and restart with
                        // this sample as channel 0.
                        err_d        = 1'b1;
                        ch_d[0 +: W] = din;
                        chv_d        = 4'b0001;
                        ptr_d        = 2'd1;
                    end else begin
                        ch_d[int'(ptr_q)*W +: W] = din;
                        chv_d                    = 4'b0001 << ptr_q;
                        if (ptr_q == 2'd3) begin
                            // Channels 0..2 are already registered; the
                            // fourth sample completes the frame directly.
                            frame_d = {din, ch_q[3*W-1:0]};
                            fv_d    = 1'b1;
                            ptr_d   = 2'd0;
                            state_d = IDLE;
                        end else begin
                            ptr_d = ptr_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    ptr_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            ch_q    <= '0;
            chv_q   <= 4'b0000;
            frame_q <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            chv_q   <= chv_d;
            frame_q <= frame_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    assign ch_out      = ch_q;
    assign ch_valid    = chv_q;
    assign frame_out   = frame_q;
    assign frame_valid = fv_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: doc/demux_14_seq.md
Name: demux_14_seq

Overview:
- Registered 1-to-4 demultiplexer. It is the distribution-side counterpart of the 4:1 mux tree in the combinational library.
- Takes one input stream and steers each valid sample to one of four channel registers.
- Channel choice comes from either an explicit select (manual mode) or an internal round-robin pointer locked to a start-of-frame marker (auto mode).
- In auto mode it reassembles complete 4-sample frames and flags framing errors.

Parameters:
- W, 4, data width of one sample and of each channel slice.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- din  input  W  input sample.
- din_valid  input  1  din is valid this cycle.
- sof  input  1  start of frame; marks the channel-0 sample. Auto mode only.
- auto_mode  input  1  1 = round-robin framed mode; 0 = manual select.
- sel  input  2  destination channel in manual mode. Ignored in auto mode.
- ch_out  output  4*W  channel registers; slice k is ch_out[k*W +: W].
- ch_valid  output  4  one-cycle pulse per channel, set when that slice was written.
- frame_out  output  4*W  last complete frame; slice k holds the channel-k sample.
- frame_valid  output  1  one-cycle pulse when frame_out is updated.
- err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (rst_n=0 at a clock edge) has priority over all inputs:
  - ch_out, ch_valid, frame_out, frame_valid and err go to 0.
  - The FSM goes to IDLE and the pointer ptr goes to 0.
- Reset mid-frame discards the partial frame; no frame_valid is produced.
- Latency: every output reflects the inputs sampled at the previous rising edge (1 cycle).
- din_valid=0: no register changes, all pulses deassert, FSM and ptr hold.
- Unwritten ch_out slices always hold their value.

Manual mode (auto_mode=0):
- On din_valid: ch_out slice sel <= din, and ch_valid = one-hot(sel).
- sof is ignored; frame_valid and err stay 0.
- While auto_mode=0 the FSM is forced to IDLE with ptr=0, so switching into auto mode always starts cleanly.

Auto mode (auto_mode=1) FSM, with states IDLE and COLLECT:
- IDLE, din_valid & sof:
  - Write slice 0 and pulse ch_valid[0].
  - ptr <= 1, go to COLLECT.
- IDLE, din_valid & !sof:
  - Sample dropped, no ch_out change, err pulse.
  - Stay in IDLE.
- COLLECT, din_valid & !sof:
  - Write slice ptr, pulse ch_valid[ptr], ptr <= ptr+1.
  - When ptr==3:
    - frame_out <= {din, ch2, ch1, ch0}, using the current channel-0..2 register contents.
    - frame_valid pulse.
    - ptr <= 0, go to IDLE.
- COLLECT, din_valid & sof (resync):
  - err pulse; the partial frame is discarded and frame_out is unchanged.
  - The sample is treated as a new channel 0: write slice 0, pulse ch_valid[0], ptr <= 1, stay in COLLECT.
- Gaps (din_valid=0) inside a frame are allowed and do not cause errors.
- auto_mode falling mid-frame:
  - FSM goes to IDLE and ptr to 0; no frame_valid, no err.
  - A valid sample in that same cycle is handled by manual-mode rules.
- Frames back-to-back with no gap are supported: sof may arrive in the cycle right after the fourth sample.
- ptr is 2 bits and never exceeds 3. No wrap occurs without a return to IDLE.

Test Plan:
- Reset, then auto_mode=0. Send din=4'hA with sel=2, then din=4'h5 with sel=0 → ch_out=16'h0A05. ch_valid is 4'b0100 then 4'b0001, each 1 cycle after its input. frame_valid=0 and err=0 throughout.
- Auto mode: send 1 (with sof), 2, 3, 4 on consecutive cycles → ch_out=16'h4321. frame_valid pulses once, 1 cycle after the 4th sample, with frame_out=16'h4321. Then send 5 (with sof), 6, 7, 8 back-to-back → second pulse with frame_out=16'h8765.
- Auto mode, same frame 1, 2, 3, 4 with din_valid=0 gaps of 0-3 cycles between samples → identical frame_out=16'h4321. err never asserts.
- Auto mode, IDLE, din=4'h7 without sof → err pulse; ch_out and ch_valid unchanged. Next, 9 (with sof), A, B, C → frame_out=16'hCBA9.
- Auto mode: send 1 (with sof), 2, then 3 with sof → err pulse and no frame_valid; slice 0 becomes 3, ptr=1. Continue with 4, 5, 6 → frame_out=16'h6543.
- Mid-frame after 2 samples, assert rst_n=0 for 1 cycle → all outputs 0. A following full frame E, D, C, B with sof on E → frame_out=16'hBCDE. Repeat the mid-frame interruption by dropping auto_mode instead → no frame_valid, no err.
